// File: rtl/mod_counter_sequencer.sv
// Run controller for a modulo-MOD counter: sequences q through a programmed number of laps.
// Optional down-count support is enabled by defining MOD_COUNTER_SEQ_DOWN_EN (adds the dir port).
module mod_counter_sequencer #(
    parameter  int MOD   = 6,
    parameter  int LAP_W = 8,
    localparam int Q_W   = $clog2(MOD)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LAP_W-1:0] num_laps,
    input  logic             pause,
    input  logic             resume,
    input  logic             abort,
`ifdef MOD_COUNTER_SEQ_DOWN_EN
    input  logic             dir,
`endif
    output logic [Q_W-1:0]   q,
    output logic             wrap,
    output logic [LAP_W-1:0] lap_cnt,
    output logic             busy,
    output logic             done
);

    localparam logic [Q_W-1:0] QMAX = Q_W'(MOD - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t           state, state_nx;
    logic [Q_W-1:0]   q_nx;
    logic             wrap_nx;
    logic [LAP_W-1:0] lap_nx;
    logic [LAP_W-1:0] tgt, tgt_nx;
    logic             down, down_nx;
    logic             start_down;

`ifdef MOD_COUNTER_SEQ_DOWN_EN
    assign start_down = dir;
`else
    assign start_down = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            q       <= '0;
            wrap    <= 1'b0;
            lap_cnt <= '0;
            tgt     <= '0;
            down    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            q       <= q_nx;
            wrap    <= wrap_nx;
            lap_cnt <= lap_nx;
            tgt     <= tgt_nx;
            down    <= down_nx;
            busy    <= (state_nx == RUN) || (state_nx == PAUSE);
            done    <= (state_nx == DONE);
        end
    end

    always_comb begin
        state_nx = state;
        q_nx     = q;
        wrap_nx  = 1'b0;
        lap_nx   = lap_cnt;
        tgt_nx   = tgt;
        down_nx  = down;
        case (state)
            IDLE: begin
                q_nx = '0;
                if (start) begin
                    tgt_nx  = num_laps;
                    lap_nx  = '0;
                    down_nx = start_down;
                    if (num_laps == '0) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = RUN;
                        q_nx     = start_down ? QMAX : '0;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    q_nx     = '0;
                    state_nx = IDLE;
                end else if (pause) begin
                    state_nx = PAUSE;
                end else if (down && (lap_cnt == tgt)) begin
                    // Down runs show the final MOD-1 for one cycle before finishing.
                    q_nx     = '0;
                    state_nx = DONE;
                end else if (!down) begin
                    if (q == QMAX) begin
                        q_nx    = '0;
                        wrap_nx = 1'b1;
                        lap_nx  = lap_cnt + 1'b1;
                        if (lap_nx == tgt) state_nx = DONE;
                    end else begin
                        q_nx = q + 1'b1;
                    end
                end else begin
                    if (q == '0) begin
                        q_nx    = QMAX;
                        wrap_nx = 1'b1;
                        lap_nx  = lap_cnt + 1'b1;
                    end else begin
                        q_nx = q - 1'b1;
                    end
                end
            end
            PAUSE: begin
                if (abort) begin
                    q_nx     = '0;
                    state_nx = IDLE;
                end else if (resume && !pause) begin
                    state_nx = RUN;
                end
            end
            DONE: begin
                q_nx     = '0;
                state_nx = IDLE;
            end
            default: begin
                q_nx     = '0;
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mod_counter_sequencer.sv
// Scoreboard bench for mod_counter_sequencer (MOD=6, LAP_W=8, up-count build).
module tb_mod_counter_sequencer;

    typedef struct packed {
        logic [2:0] q;
        logic       wrap;
        logic [7:0] lap;
        logic       busy;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] num_laps = '0;
    logic       pause = 1'b0;
    logic       resume = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] q;
    logic       wrap;
    logic [7:0] lap_cnt;
    logic       busy;
    logic       done;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    mod_counter_sequencer #(.MOD(6), .LAP_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .num_laps(num_laps),
        .pause(pause), .resume(resume), .abort(abort),
        .q(q), .wrap(wrap), .lap_cnt(lap_cnt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Monitor: one expected response per clock edge, checked just after the edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            if (q !== e.q || wrap !== e.wrap || lap_cnt !== e.lap || busy !== e.busy || done !== e.done) begin
                miscompares++;
                $display("FAIL vec%0d: got q=%0d wrap=%0b lap=%0d busy=%0b done=%0b, want q=%0d wrap=%0b lap=%0d busy=%0b done=%0b",
                         vectors, q, wrap, lap_cnt, busy, done, e.q, e.wrap, e.lap, e.busy, e.done);
            end
        end
    end

    task automatic step(input logic st, input logic [7:0] nl, input logic pa, input logic re,
                        input logic ab, input logic rs, input logic [2:0] eq, input logic ew,
                        input logic [7:0] el, input logic eb, input logic ed);
        exp_t e;
        start = st; num_laps = nl; pause = pa; resume = re; abort = ab; reset = rs;
        e.q = eq; e.wrap = ew; e.lap = el; e.busy = eb; e.done = ed;
        sb.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d expected responses pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        step(0, 0, 0, 0, 0, 1, 3'd0, 0, 8'd0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 3'd0, 0, 8'd0, 0, 0);

        // Two laps, no pause: done 12 edges after the start edge; num_laps changes ignored while busy
        step(1, 8'd2, 0, 0, 0, 0, 3'd0, 0, 8'd0, 1, 0);
        for (int e = 1; e <= 12; e++)
            step(0, 8'd7, 0, 0, 0, 0, 3'(e % 6), (e % 6) == 0, 8'(e / 6), e < 12, e == 12);
        step(0, 8'd0, 0, 0, 0, 0, 3'd0, 0, 8'd2, 0, 0);

        // Zero laps: straight to DONE, busy never high
        step(1, 8'd0, 0, 0, 0, 0, 3'd0, 0, 8'd0, 0, 1);
        step(1, 8'd0, 0, 0, 0, 0, 3'd0, 0, 8'd0, 0, 0);
        step(0, 8'd0, 0, 0, 0, 0, 3'd0, 0, 8'd0, 0, 0);

        // One lap with a pause at q=3; resume while pause still high is not honoured
        step(1, 8'd1, 0, 0, 0, 0, 3'd0, 0, 8'd0, 1, 0);
        for (int e = 1; e <= 3; e++)
            step(0, 8'd1, 0, 0, 0, 0, 3'(e), 0, 8'd0, 1, 0);
        step(0, 8'd1, 1, 0, 0, 0, 3'd3, 0, 8'd0, 1, 0);
        step(0, 8'd1, 1, 1, 0, 0, 3'd3, 0, 8'd0, 1, 0);
        step(0, 8'd1, 0, 1, 0, 0, 3'd3, 0, 8'd0, 1, 0);
        step(0, 8'd1, 0, 0, 0, 0, 3'd4, 0, 8'd0, 1, 0);
        step(0, 8'd1, 0, 0, 0, 0, 3'd5, 0, 8'd0, 1, 0);
        step(0, 8'd1, 0, 0, 0, 0, 3'd0, 1, 8'd1, 0, 1);
        step(0, 8'd1, 0, 0, 0, 0, 3'd0, 0, 8'd1, 0, 0);

        // Three laps, abort at lap_cnt=1 q=2; controls ignored in IDLE; then a clean one-lap run
        step(1, 8'd3, 0, 0, 0, 0, 3'd0, 0, 8'd0, 1, 0);
        for (int e = 1; e <= 8; e++)
            step(0, 8'd3, 0, 0, 0, 0, 3'(e % 6), (e % 6) == 0, 8'(e / 6), 1, 0);
        step(0, 8'd3, 0, 0, 1, 0, 3'd0, 0, 8'd1, 0, 0);
        step(0, 8'd3, 1, 1, 1, 0, 3'd0, 0, 8'd1, 0, 0);
        step(1, 8'd1, 0, 0, 0, 0, 3'd0, 0, 8'd0, 1, 0);
        for (int e = 1; e <= 6; e++)
            step(0, 8'd1, 0, 0, 0, 0, 3'(e % 6), e == 6, 8'(e / 6), e < 6, e == 6);
        step(0, 8'd1, 0, 0, 0, 0, 3'd0, 0, 8'd1, 0, 0);

        // Start while busy is ignored; reset mid-run at q=4
        step(1, 8'd5, 0, 0, 0, 0, 3'd0, 0, 8'd0, 1, 0);
        step(0, 8'd5, 0, 0, 0, 0, 3'd1, 0, 8'd0, 1, 0);
        step(1, 8'd1, 0, 0, 0, 0, 3'd2, 0, 8'd0, 1, 0);
        step(0, 8'd1, 0, 0, 0, 0, 3'd3, 0, 8'd0, 1, 0);
        step(0, 8'd1, 0, 0, 0, 0, 3'd4, 0, 8'd0, 1, 0);
        step(0, 8'd1, 0, 0, 0, 1, 3'd0, 0, 8'd0, 0, 0);
        step(0, 8'd1, 0, 0, 0, 0, 3'd0, 0, 8'd0, 0, 0);

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected responses never checked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
